// File: rtl/dff_bank_arbiter_pkg.sv
// Shared types and defaults for the register-bank write-port arbiter.
package dff_bank_arbiter_pkg;

    localparam int DEF_AW = 3;
    localparam int DEF_DW = 8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Successor of requester index i in a ring of n requesters.
    function automatic logic [2:0] next_idx(input logic [2:0] i, input int unsigned n);
        return 3'((32'(i) + 32'd1) % n);
    endfunction

endpackage

// File: rtl/dff_bank_arbiter_if.sv
// Request/grant and read bus between requesters and the bank arbiter.
interface dff_bank_arbiter_if #(
    parameter int N  = 4,
    parameter int DW = dff_bank_arbiter_pkg::DEF_DW,
    parameter int AW = dff_bank_arbiter_pkg::DEF_AW
);
    logic [N-1:0]    req;
    logic [N-1:0]    lock;
    logic [N*AW-1:0] waddr;
    logic [N*DW-1:0] wdata;
    logic [AW-1:0]   raddr;
    logic [N-1:0]    gnt;
    logic [DW-1:0]   rdata;
    logic            burst_active;
    logic [2:0]      owner;

    modport master (
        output req, lock, waddr, wdata, raddr,
        input  gnt, rdata, burst_active, owner
    );

    modport slave (
        input  req, lock, waddr, wdata, raddr,
        output gnt, rdata, burst_active, owner
    );
endinterface

// File: rtl/dff_bank_arbiter_word.sv
// One bank word: DW-bit register with load enable, async active-low clear.
module dff_word #(
    parameter int DW = dff_bank_arbiter_pkg::DEF_DW
) (
    input  logic          Clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst)
            q <= '0;
        else if (en)
            q <= d;
    end
endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter with bounded lock bursts; sole writer of a DFF register bank.
module dff_bank_arbiter
    import dff_bank_arbiter_pkg::*;
#(
    parameter int N         = 4,
    parameter int DW        = DEF_DW,
    parameter int AW        = DEF_AW,
    parameter int MAX_BURST = 4
) (
    input logic             Clk,
    input logic             rst,
    dff_bank_arbiter_if.slave bus
);
    localparam int CW    = $clog2(MAX_BURST) + 1;
    localparam int DEPTH = 1 << AW;

    state_t        state, state_nx;
    logic [2:0]    ptr, ptr_nx, own, own_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [N-1:0]  req_rot, gnt_c;
    logic [2:0]    pick_rot, win;
    logic          any;

    // Rotate requests so ptr sits at bit 0, pick lowest, rotate the index back.
    always_comb begin
        req_rot  = '0;
        pick_rot = '0;
        any      = 1'b0;
        for (int unsigned j = 0; j < N; j++)
            req_rot[j] = bus.req[(j + 32'(ptr)) % N];
        for (int unsigned j = 0; j < N; j++) begin
            if (!any && req_rot[j]) begin
                any      = 1'b1;
                pick_rot = 3'(j);
            end
        end
        win = 3'((32'(pick_rot) + 32'(ptr)) % N);
    end

    always_comb begin
        gnt_c    = '0;
        state_nx = state;
        ptr_nx   = ptr;
        own_nx   = own;
        cnt_nx   = cnt;
        unique case (state)
            ST_IDLE: begin
                if (any) begin
                    gnt_c[win] = 1'b1;
                    ptr_nx     = next_idx(win, N);
                    own_nx     = win;
                    if (bus.lock[win] && MAX_BURST > 1) begin
                        state_nx = ST_LOCKED;
                        cnt_nx   = CW'(1);
                    end
                end
            end
            ST_LOCKED: begin
                if (bus.req[own]) begin
                    gnt_c[own] = 1'b1;
                    ptr_nx     = next_idx(own, N);
                    if (!bus.lock[own] || (32'(cnt) + 32'd1 == 32'(MAX_BURST))) begin
                        state_nx = ST_IDLE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end else begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            ptr   <= '0;
            own   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            own   <= own_nx;
            cnt   <= cnt_nx;
        end
    end

    // Grant is masked by reset so it drops without waiting for a clock edge.
    assign bus.gnt          = rst ? gnt_c : '0;
    assign bus.burst_active = (state == ST_LOCKED);
    assign bus.owner        = own;

    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;

    always_comb begin
        wa = '0;
        wd = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (bus.gnt[i]) begin
                wa = bus.waddr[i*AW +: AW];
                wd = bus.wdata[i*DW +: DW];
            end
        end
    end

    assign we = |bus.gnt;

    logic [DW-1:0] bank [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_word
        dff_word #(.DW(DW)) u_word (
            .Clk (Clk),
            .rst (rst),
            .en  (we && (wa == AW'(k))),
            .d   (wd),
            .q   (bank[k])
        );
    end

    assign bus.rdata = bank[bus.raddr];

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Scoreboard bench for dff_bank_arbiter: directed plan plus randomized traffic.
module tb_dff_bank_arbiter;
    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int AW   = 3;
    localparam int MAXB = 4;

    logic Clk = 1'b0;
    logic rst = 1'b0;
    always #5 Clk = ~Clk;

    dff_bank_arbiter_if #(.N(N), .DW(DW), .AW(AW)) bus ();

    dff_bank_arbiter #(.N(N), .DW(DW), .AW(AW), .MAX_BURST(MAXB)) dut (
        .Clk (Clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0] gnt;
        logic [7:0] rdata;
        logic       ba;
        logic [2:0] owner;
    } exp_t;

    exp_t q[$];
    int tests  = 0;
    int failed = 0;
    int cycle_no = 0;

    // Reference model state: who holds the port and how many beats it used.
    int m_ptr, m_last, m_lock_owner, m_beats;
    logic [7:0] mbank [8];

    task automatic model_reset();
        m_ptr = 0; m_last = 0; m_lock_owner = -1; m_beats = 0;
        for (int a = 0; a < 8; a++) mbank[a] = 8'h00;
    endtask

    task automatic cyc(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                       input logic [11:0] wa, input logic [31:0] wd, input logic [2:0] ra);
        exp_t e;
        int g;
        @(negedge Clk);
        rst = r; bus.req = rq; bus.lock = lk; bus.waddr = wa; bus.wdata = wd; bus.raddr = ra;
        if (!r) begin
            model_reset();
            e = '{gnt: 4'b0, rdata: 8'h00, ba: 1'b0, owner: 3'd0};
            q.push_back(e);
            return;
        end
        g = -1;
        if (m_lock_owner >= 0) begin
            if (rq[m_lock_owner]) g = m_lock_owner;
        end else begin
            for (int k = 0; k < N; k++)
                if (g < 0 && rq[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
        e.gnt   = (g >= 0) ? 4'(1 << g) : 4'b0;
        e.rdata = mbank[ra];
        e.ba    = (m_lock_owner >= 0);
        e.owner = 3'(m_last);
        q.push_back(e);
        if (g >= 0) begin
            mbank[wa[g*3 +: 3]] = wd[g*8 +: 8];
            m_ptr  = (g + 1) % N;
            m_last = g;
            if (m_lock_owner >= 0) begin
                m_beats++;
                if (!lk[g] || m_beats == MAXB) begin m_lock_owner = -1; m_beats = 0; end
            end else if (lk[g] && MAXB > 1) begin
                m_lock_owner = g; m_beats = 1;
            end
        end else if (m_lock_owner >= 0) begin
            m_lock_owner = -1; m_beats = 0;
        end
    endtask

    // Monitor: compare DUT outputs against the queued expectation each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            #2;
            cycle_no++;
            if (q.size() > 0) begin
                e = q.pop_front();
                tests++;
                if ({bus.gnt, bus.rdata, bus.burst_active, bus.owner} !== e) begin
                    failed++;
                    $display("FAIL cyc%0d: gnt=%b want %b rdata=%h want %h burst_active=%b want %b owner=%0d want %0d",
                             cycle_no, bus.gnt, e.gnt, bus.rdata, e.rdata, bus.burst_active, e.ba,
                             bus.owner, e.owner);
                end
            end
        end
    end

    localparam logic [11:0] WA_ID = {3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [31:0] WD_A  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    initial begin
        bus.req = '0; bus.lock = '0; bus.waddr = '0; bus.wdata = '0; bus.raddr = '0;
        model_reset();
        // Reset held with all requesting: no grants, bank reads zero.
        for (int a = 0; a < 8; a++) cyc(1'b0, 4'b1111, 4'b0, WA_ID, WD_A, 3'(a));
        // Round-robin from ptr=0.
        for (int c = 0; c < 4; c++) cyc(1'b1, 4'b1111, 4'b0, WA_ID, WD_A, 3'd0);
        for (int a = 0; a < 4; a++) cyc(1'b1, 4'b0000, 4'b0, WA_ID, WD_A, 3'(a));
        // Locked burst of MAXB beats, then requester 1.
        for (int c = 0; c < 5; c++) cyc(1'b1, 4'b0011, 4'b0001, 12'd0, 32'h0000_1122, 3'd0);
        // Early unlock on second beat.
        cyc(1'b1, 4'b0100, 4'b0100, 12'd0, 32'h0033_0000, 3'd0);
        cyc(1'b1, 4'b0100, 4'b0000, 12'd0, 32'h0044_0000, 3'd0);
        cyc(1'b1, 4'b1000, 4'b0000, 12'd0, 32'h5500_0000, 3'd0);
        // Owner drops req in beat 2: one idle cycle, then requester 3.
        cyc(1'b1, 4'b1100, 4'b0100, 12'd0, 32'h6666_6666, 3'd0);
        cyc(1'b1, 4'b1000, 4'b0100, 12'd0, 32'h7777_7777, 3'd0);
        cyc(1'b1, 4'b1000, 4'b0000, 12'd0, 32'h8888_8888, 3'd0);
        // Same-cycle read/write of address 5.
        cyc(1'b1, 4'b0010, 4'b0000, 12'd5 << 3, 32'h5C << 8, 3'd5);
        cyc(1'b1, 4'b0000, 4'b0000, 12'd0, 32'h0, 3'd5);
        // Reset during beat 2 of a locked burst.
        cyc(1'b1, 4'b0001, 4'b0001, 12'd1, 32'h99, 3'd1);
        cyc(1'b0, 4'b0001, 4'b0001, 12'd1, 32'h99, 3'd1);
        cyc(1'b0, 4'b0001, 4'b0001, 12'd5, 32'h99, 3'd5);
        cyc(1'b1, 4'b1111, 4'b0000, 12'd0, 32'h0, 3'd5);
        // Randomized traffic with occasional reset pulses.
        for (int c = 0; c < 600; c++) begin
            logic [3:0] rq, lk;
            rq = 4'($urandom);
            lk = ($urandom_range(0, 2) != 0) ? 4'($urandom) : 4'b0;
            cyc(($urandom_range(0, 79) != 0), rq, lk, 12'($urandom), $urandom, 3'($urandom));
        end
        @(negedge Clk);
        #3;
        if (q.size() != 0) begin
            failed++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
